// File: rtl/rggen_bit_field_set_buffer.sv
// Set-request FIFO feeding the hardware-set path of a read-write-set field.
// Define RGGEN_SET_BUFFER_MERGE_EN to OR-merge requests into the newest entry when full.
module rggen_bit_field_set_buffer #(
   parameter int WIDTH       = 8,
   parameter int DEPTH       = 4,
   parameter int WRITE_FIRST = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic [WIDTH-1:0]           i_req_value,
   input  logic                       i_sw_write,
   output logic                       o_set,
   output logic [WIDTH-1:0]           o_value,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_blocked
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q;
   logic [PW-1:0]    rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    wr_ptr_d;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             full;
   logic             pop;
   logic             push;

   // Depth need not be a power of two, so wrap by compare.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   assign full      = (count_q == FULL_CNT);
   assign o_set     = (count_q != '0);
   assign o_blocked = o_set && (WRITE_FIRST != 0) && i_sw_write;
   assign pop       = o_set && !o_blocked;
   assign o_value   = o_set ? entry_q[rd_ptr_q] : '0;
   assign o_count   = count_q;

`ifdef RGGEN_SET_BUFFER_MERGE_EN
   logic          merge;
   logic [PW-1:0] newest;

   assign o_req_ready = 1'b1;
   assign push        = i_req_valid && (!full || pop);
   assign merge       = i_req_valid && full && !pop;
   assign newest      = (wr_ptr_q == '0) ? LAST : wr_ptr_q - 1'b1;
`else
   assign o_req_ready = !full;
   assign push        = i_req_valid && o_req_ready;
`endif

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (push) begin
            entry_q[wr_ptr_q] <= i_req_value;
         end
`ifdef RGGEN_SET_BUFFER_MERGE_EN
         else if (merge) begin
            entry_q[newest] <= entry_q[newest] | i_req_value;
         end
`endif
      end
   end

endmodule

// File: tb/tb_rggen_bit_field_set_buffer.sv
// Bench for rggen_bit_field_set_buffer: queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_rggen_bit_field_set_buffer;

   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0;
   logic [7:0]    value = 8'h00;
   logic          sw = 1'b0;
   logic          ready;
   logic          set;
   logic [7:0]    oval;
   logic [CW-1:0] count;
   logic          blocked;

   int total = 0;
   int bad   = 0;
   bit started = 1'b0;
   logic [7:0] q[$];

   rggen_bit_field_set_buffer #(
      .WIDTH(8), .DEPTH(DEPTH), .WRITE_FIRST(1)
   ) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(valid), .o_req_ready(ready),
      .i_req_value(value), .i_sw_write(sw),
      .o_set(set), .o_value(oval),
      .o_count(count), .o_blocked(blocked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference: a plain queue of pending set values.
   always @(posedge clk) begin
      bit m_full;
      bit m_pop;
      bit m_push;
      bit m_merge;
      if (rst) begin
         q.delete();
         started = 1'b1;
      end else begin
         m_full  = (q.size() == DEPTH);
         m_pop   = (q.size() != 0) && !sw;
         m_merge = 1'b0;
`ifdef RGGEN_SET_BUFFER_MERGE_EN
         m_push  = valid && (!m_full || m_pop);
         m_merge = valid && m_full && !m_pop;
`else
         m_push  = valid && !m_full;
`endif
         if (m_merge) q[q.size()-1] = q[q.size()-1] | value;
         if (m_pop) void'(q.pop_front());
         if (m_push) q.push_back(value);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("m_count", int'(count), q.size());
         chk("m_set", int'(set), int'(q.size() != 0));
         chk("m_value", int'(oval), (q.size() != 0) ? int'(q[0]) : 0);
         chk("m_blocked", int'(blocked), int'((q.size() != 0) && sw));
`ifdef RGGEN_SET_BUFFER_MERGE_EN
         chk("m_ready", int'(ready), 1);
`else
         chk("m_ready", int'(ready), int'(q.size() < DEPTH));
`endif
      end
   end

   task automatic drive(input logic r, input logic v,
                        input logic [7:0] d, input logic s);
      @(posedge clk);
      #1;
      rst = r; valid = v; value = d; sw = s;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 1'b1, 8'h33, 1'b0);
      // single request, one-cycle latency
      drive(1'b0, 1'b1, 8'h5A, 1'b0);
      chk("rst_set", int'(set), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_ready", int'(ready), 1);
      idle(1);
      chk("lat_set", int'(set), 1);
      chk("lat_value", int'(oval), 8'h5A);
      chk("lat_count", int'(count), 1);
      idle(1);
      chk("lat_empty", int'(count), 0);

      // software write blocks the head for three cycles
      drive(1'b0, 1'b1, 8'h11, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         chk("blk_flag", int'(blocked), 1);
         chk("blk_value", int'(oval), 8'h11);
         chk("blk_count", int'(count), 1);
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      chk("blk_release", int'(blocked), 0);
      idle(1);
      chk("blk_popped", int'(count), 0);

      // fill, then a held request across the wrap
      drive(1'b0, 1'b1, 8'h01, 1'b1);
      drive(1'b0, 1'b1, 8'h02, 1'b1);
      drive(1'b0, 1'b1, 8'h03, 1'b1);
      drive(1'b0, 1'b1, 8'h04, 1'b0);
      chk("full_count", int'(count), 3);
`ifndef RGGEN_SET_BUFFER_MERGE_EN
      chk("full_ready", int'(ready), 0);
`endif
      chk("wrap_v1", int'(oval), 8'h01);
      drive(1'b0, 1'b1, 8'h04, 1'b0);
      chk("wrap_v2", int'(oval), 8'h02);
      idle(1);
      chk("wrap_v3", int'(oval), 8'h03);
      idle(1);
      chk("wrap_v4", int'(oval), 8'h04);
      idle(3);

      // streaming at count 2
      drive(1'b0, 1'b1, 8'hA0, 1'b1);
      drive(1'b0, 1'b1, 8'hA1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 8'hA2 + 8'(i), 1'b0);
         chk("strm_count", int'(count), 2);
         chk("strm_value", int'(oval), 8'hA0 + i);
      end
      idle(3);

      // reset flushes a full queue
      drive(1'b0, 1'b1, 8'hB0, 1'b1);
      drive(1'b0, 1'b1, 8'hB1, 1'b1);
      drive(1'b0, 1'b1, 8'hB2, 1'b1);
      drive(1'b1, 1'b1, 8'hEE, 1'b0);
      chk("flush_pre", int'(count), 3);
      drive(1'b0, 1'b1, 8'h7F, 1'b0);
      chk("flush_set", int'(set), 0);
      chk("flush_count", int'(count), 0);
      chk("flush_ready", int'(ready), 1);
      idle(1);
      chk("flush_first", int'(oval), 8'h7F);
      idle(2);

`ifdef RGGEN_SET_BUFFER_MERGE_EN
      drive(1'b0, 1'b1, 8'h01, 1'b1);
      drive(1'b0, 1'b1, 8'h10, 1'b1);
      drive(1'b0, 1'b1, 8'h20, 1'b1);
      drive(1'b0, 1'b1, 8'h40, 1'b1);
      chk("mrg_full", int'(count), 3);
      idle(1);
      chk("mrg_count", int'(count), 3);
      chk("mrg_v1", int'(oval), 8'h01);
      idle(1);
      chk("mrg_v2", int'(oval), 8'h10);
      idle(1);
      chk("mrg_v3", int'(oval), 8'h60);
      idle(1);
      chk("mrg_empty", int'(count), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
